// File: rtl/timer_bridge_pkg.sv
// Shared constants for the timer bridge: register offsets, default device
// bases and the aux arbitration FSM encoding.
package timer_bridge_pkg;

  localparam logic [1:0] CTRL   = 2'd0;
  localparam logic [1:0] PRESET = 2'd1;
  localparam logic [1:0] COUNT  = 2'd2;

  localparam logic [31:0] T0_BASE_DEF = 32'h0000_7F00;
  localparam logic [31:0] T1_BASE_DEF = 32'h0000_7F10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/timer_addr_decode.sv
// Maps a byte address onto {valid, timer select, register offset}.
// Each timer occupies a 16-byte aligned window with three word registers.
module timer_addr_decode
  import timer_bridge_pkg::*;
#(
  parameter logic [31:0] T0_BASE = T0_BASE_DEF,
  parameter logic [31:0] T1_BASE = T1_BASE_DEF
) (
  input  logic [31:0] addr,
  output logic        valid,
  output logic        sel,
  output logic [1:0]  inner
);

  logic in_t0;
  logic in_t1;
  logic reg_ok;
  logic unused_byte_lane;

  assign in_t0  = addr[31:4] == T0_BASE[31:4];
  assign in_t1  = addr[31:4] == T1_BASE[31:4];
  assign reg_ok = (addr[3:2] == CTRL) | (addr[3:2] == PRESET) | (addr[3:2] == COUNT);

  assign valid = (in_t0 | in_t1) & reg_ok;
  assign sel   = ~in_t0 & in_t1;
  assign inner = addr[3:2];

  // Accesses are word-wide; the byte lane bits carry no information here.
  assign unused_byte_lane = ^addr[1:0];

endmodule

// File: rtl/timer_bridge.sv
// Bridge from the CPU data port and an aux bus master to two timers.
// The CPU wins by default; a blocked aux request stalls the CPU once after MAX_WAIT.
//
// Aux handshake: aux_req is held with stable fields until the single-cycle
// aux_ack pulse; dropping aux_req before issue abandons the access, and
// aux_rdata/aux_err are only meaningful while aux_ack is high.
module timer_bridge
  import timer_bridge_pkg::*;
#(
  parameter logic [31:0] T0_BASE  = T0_BASE_DEF,
  parameter logic [31:0] T1_BASE  = T1_BASE_DEF,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        cpu_hit,
  output logic        cpu_stall,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wd,
  output logic        aux_ack,
  output logic [31:0] aux_rdata,
  output logic        aux_err,
  output logic [1:0]  t0_addr,
  output logic        t0_we,
  output logic [31:0] t0_wd,
  input  logic [31:0] t0_rd,
  output logic [1:0]  t1_addr,
  output logic        t1_we,
  output logic [31:0] t1_wd,
  input  logic [31:0] t1_rd,
  input  logic        t0_irq,
  input  logic        t1_irq,
  output logic [5:0]  hwint,
  output logic [1:0]  dbg_state
);

  state_t     state;
  logic [3:0] wait_cnt;

  logic       cpu_valid, cpu_sel, aux_valid, aux_sel;
  logic [1:0] cpu_inner, aux_inner;
  logic       cpu_raw_hit, at_limit, aux_issue, starve;
  logic       we_any, we_sel;
  logic [31:0] aux_rd_sel;

  timer_addr_decode #(.T0_BASE(T0_BASE), .T1_BASE(T1_BASE)) u_cpu_dec (
    .addr(cpu_addr), .valid(cpu_valid), .sel(cpu_sel), .inner(cpu_inner)
  );

  timer_addr_decode #(.T0_BASE(T0_BASE), .T1_BASE(T1_BASE)) u_aux_dec (
    .addr(aux_addr), .valid(aux_valid), .sel(aux_sel), .inner(aux_inner)
  );

  assign cpu_raw_hit = cpu_req & cpu_valid;
  assign at_limit    = wait_cnt == 4'(MAX_WAIT);

  // Reset gates the issue so an access caught mid-flight never writes.
  always_comb begin
    aux_issue = 1'b0;
    if (!RST && aux_req) begin
      case (state)
        IDLE:    aux_issue = ~cpu_raw_hit;
        WAIT:    aux_issue = ~cpu_raw_hit | at_limit;
        default: aux_issue = 1'b0;
      endcase
    end
  end

  assign starve    = aux_issue & cpu_raw_hit;
  assign cpu_stall = starve;
  assign cpu_hit   = cpu_raw_hit & ~starve;
  assign dbg_state = state;

  always_comb begin
    if (aux_issue) begin
      we_any = aux_we & aux_valid;
      we_sel = aux_sel;
    end else begin
      we_any = cpu_hit & cpu_we;
      we_sel = cpu_sel;
    end
    t0_addr    = aux_issue ? aux_inner : cpu_inner;
    t1_addr    = t0_addr;
    t0_wd      = aux_issue ? aux_wd : cpu_wd;
    t1_wd      = t0_wd;
    t0_we      = we_any & ~we_sel;
    t1_we      = we_any & we_sel;
    cpu_rd     = cpu_hit ? (cpu_sel ? t1_rd : t0_rd) : 32'd0;
    aux_rd_sel = aux_valid ? (aux_sel ? t1_rd : t0_rd) : 32'd0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      aux_ack   <= 1'b0;
      aux_err   <= 1'b0;
      aux_rdata <= 32'd0;
      hwint     <= 6'd0;
    end else begin
      hwint   <= {4'b0, t1_irq, t0_irq};
      aux_ack <= aux_issue;
      if (aux_issue) begin
        aux_rdata <= aux_rd_sel;
        aux_err   <= ~aux_valid;
      end
      case (state)
        IDLE: begin
          if (aux_issue) begin
            state <= ACK;
          end else if (aux_req) begin
            state    <= WAIT;
            wait_cnt <= 4'd1;
          end
        end
        WAIT: begin
          if (!aux_req) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
          end else if (aux_issue) begin
            state    <= ACK;
            wait_cnt <= 4'd0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_bridge.sv
// Randomized and directed stimulus for timer_bridge, checked by a scoreboard
// fed from a behavioural arbitration model.
module tb_timer_bridge;

  localparam logic [31:0] T0 = 32'h0000_7F00;
  localparam logic [31:0] T1 = 32'h0000_7F10;
  localparam int MAX_WAIT = 4;

  logic        CLK, RST;
  logic        cpu_req, cpu_we, cpu_hit, cpu_stall;
  logic [31:0] cpu_addr, cpu_wd, cpu_rd;
  logic        aux_req, aux_we, aux_ack, aux_err;
  logic [31:0] aux_addr, aux_wd, aux_rdata;
  logic [1:0]  t0_addr, t1_addr;
  logic        t0_we, t1_we, t0_irq, t1_irq;
  logic [31:0] t0_wd, t1_wd, t0_rd, t1_rd;
  logic [5:0]  hwint;
  logic [1:0]  dbg_state;

  timer_bridge #(.T0_BASE(T0), .T1_BASE(T1), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_hit(cpu_hit), .cpu_stall(cpu_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wd(aux_wd),
    .aux_ack(aux_ack), .aux_rdata(aux_rdata), .aux_err(aux_err),
    .t0_addr(t0_addr), .t0_we(t0_we), .t0_wd(t0_wd), .t0_rd(t0_rd),
    .t1_addr(t1_addr), .t1_we(t1_we), .t1_wd(t1_wd), .t1_rd(t1_rd),
    .t0_irq(t0_irq), .t1_irq(t1_irq), .hwint(hwint), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Timer register model: read data encodes which timer and register was addressed.
  logic [31:0] rd_salt;
  always_comb t0_rd = {rd_salt[31:4], 1'b0, 1'b0, t0_addr};
  always_comb t1_rd = {rd_salt[31:4], 1'b1, 1'b0, t1_addr};

  function automatic logic [31:0] rd_val(input logic s, input logic [1:0] i);
    return {rd_salt[31:4], s, 1'b0, i};
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [33:0] cpu_q[$];   // {hit, stall, rd}
  logic [34:0] wr_q[$];    // {timer, reg, data}
  logic [64:0] aux_q[$];   // {due cycle, err, rdata}
  logic [1:0]  irq_q[$];   // expected hwint low bits, one per cycle

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic        rst_i, c_req, c_we, a_req, a_we, i0, i1;
  logic [31:0] c_addr, c_wd, a_addr, a_wd;
  int          blocked = 0;   // consecutive cycles the current aux request lost to the CPU
  logic        in_ack  = 1'b0;

  function automatic void dec(input logic [31:0] a, output logic v, output logic s,
                              output logic [1:0] i);
    if (a >= T0 && a < T0 + 32'd12) begin
      v = 1'b1; s = 1'b0; i = 2'((a - T0) >> 2);
    end else if (a >= T1 && a < T1 + 32'd12) begin
      v = 1'b1; s = 1'b1; i = 2'((a - T1) >> 2);
    end else begin
      v = 1'b0; s = 1'b0; i = 2'd0;
    end
  endfunction

  task automatic step();
    logic cv, cs, av, asel, raw, issue, stall, hit;
    logic [1:0] ci, ai;
    @(negedge CLK);
    cyc++;
    RST = rst_i; cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wd = c_wd;
    aux_req = a_req; aux_we = a_we; aux_addr = a_addr; aux_wd = a_wd;
    t0_irq = i0; t1_irq = i1;
    dec(c_addr, cv, cs, ci);
    dec(a_addr, av, asel, ai);
    raw   = c_req && cv;
    issue = 1'b0;
    stall = 1'b0;
    if (!rst_i && !in_ack && a_req && (!raw || blocked == MAX_WAIT)) begin
      issue = 1'b1;
      stall = raw;
    end
    hit = raw && !stall;
    cpu_q.push_back({hit, stall, hit ? rd_val(cs, ci) : 32'd0});
    if (issue) begin
      aux_q.push_back({32'(cyc + 1), !av, av ? rd_val(asel, ai) : 32'd0});
      if (av && a_we) wr_q.push_back({asel, ai, a_wd});
    end else if (hit && c_we) begin
      wr_q.push_back({cs, ci, c_wd});
    end
    if (rst_i || in_ack || !a_req || issue) blocked = 0;
    else blocked++;
    in_ack = issue;
    irq_q.push_back(rst_i ? 2'b00 : {i1, i0});
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [33:0] ec;
    logic [34:0] ew;
    logic [64:0] ea;
    logic [1:0]  ei;
    forever begin
      @(negedge CLK);
      #2;
      if (cpu_q.size() > 0) begin
        ec = cpu_q.pop_front();
        check("cpu_hit", cpu_hit, ec[33]);
        check("cpu_stall", cpu_stall, ec[32]);
        check("cpu_rd", cpu_rd, ec[31:0]);
      end
      check("dual_we", t0_we & t1_we, 0);
      if (t0_we || t1_we) begin
        check("write_expected", wr_q.size() > 0, 1);
        if (wr_q.size() > 0) begin
          ew = wr_q.pop_front();
          check("write_target", {t1_we, t1_we ? t1_addr : t0_addr}, ew[34:32]);
          check("write_data", t1_we ? t1_wd : t0_wd, ew[31:0]);
        end
      end else if (wr_q.size() > 0) begin
        check("write_missing", wr_q.size(), 0);
        wr_q.delete();
      end
      if (aux_ack) begin
        check("ack_expected", aux_q.size() > 0, 1);
        if (aux_q.size() > 0) begin
          ea = aux_q.pop_front();
          check("ack_cycle", cyc, ea[64:33]);
          check("aux_err", aux_err, ea[32]);
          check("aux_rdata", aux_rdata, ea[31:0]);
        end
      end else if (aux_q.size() > 0 && int'(aux_q[0][64:33]) <= cyc) begin
        ea = aux_q.pop_front();
        check("ack_missing", cyc, ea[64:33] - 1);
      end
      if (irq_q.size() >= 2) begin
        ei = irq_q.pop_front();
        check("hwint", hwint, {4'b0, ei});
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: a = T0 + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 3));
      4, 5, 6, 7: a = T1 + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 3));
      8:          a = ($urandom_range(0, 1) ? T1 : T0) + 32'd12 + 32'($urandom_range(0, 3));
      default:    a = $urandom();
    endcase
    return a;
  endfunction

  task automatic quiet();
    c_req = 1'b0; c_we = 1'b0; c_addr = 32'd0; c_wd = 32'd0;
    a_req = 1'b0; a_we = 1'b0; a_addr = 32'd0; a_wd = 32'd0;
  endtask

  initial begin
    logic busy, drop_next;
    rd_salt = $urandom();
    RST = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wd = 32'd0;
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = 32'd0; aux_wd = 32'd0;
    t0_irq = 1'b0; t1_irq = 1'b0;
    irq_q.push_back(2'b00);
    quiet(); i0 = 1'b0; i1 = 1'b0;

    rst_i = 1'b1;
    repeat (3) step();
    rst_i = 1'b0;
    step(); #2;
    check("reset_aux_ack", aux_ack, 0);
    check("reset_aux_err", aux_err, 0);
    check("reset_aux_rdata", aux_rdata, 0);
    check("reset_hwint", hwint, 0);
    check("reset_cpu_stall", cpu_stall, 0);

    // CPU store to timer 0 CTRL
    c_req = 1; c_we = 1; c_addr = 32'h7F00; c_wd = 32'h9;
    step(); #2;
    check("cpu_store_t0_we", t0_we, 1);
    check("cpu_store_t0_addr", t0_addr, 0);
    check("cpu_store_t0_wd", t0_wd, 32'h9);
    check("cpu_store_t1_we", t1_we, 0);
    check("cpu_store_hit", cpu_hit, 1);
    check("cpu_store_stall", cpu_stall, 0);
    quiet();

    // Aux read of timer 1 PRESET with the CPU idle
    a_req = 1; a_we = 0; a_addr = 32'h7F14;
    step(); #2;
    check("aux_rd_no_early_ack", aux_ack, 0);
    step(); #2;
    check("aux_rd_ack", aux_ack, 1);
    check("aux_rd_data", aux_rdata, rd_val(1'b1, 2'd1));
    check("aux_rd_err", aux_err, 0);
    a_req = 0;
    step(); #2;
    check("aux_rd_ack_one_cycle", aux_ack, 0);

    // Aux write starved by back-to-back CPU hits
    a_req = 1; a_we = 1; a_addr = 32'h7F04; a_wd = $urandom();
    c_req = 1; c_we = 0; c_addr = 32'h7F10;
    for (int k = 0; k < MAX_WAIT; k++) begin
      step(); #2;
      check("starve_blocked_stall", cpu_stall, 0);
      check("starve_blocked_we", t0_we, 0);
    end
    step(); #2;
    check("starve_stall", cpu_stall, 1);
    check("starve_cpu_hit", cpu_hit, 0);
    check("starve_t0_we", t0_we, 1);
    check("starve_t0_addr", t0_addr, 1);
    check("starve_t0_wd", t0_wd, a_wd);
    step(); #2;
    check("starve_ack", aux_ack, 1);
    check("starve_post_stall", cpu_stall, 0);
    quiet();

    // Invalid aux addresses and an invalid CPU access
    a_req = 1; a_we = 1; a_addr = 32'h7F0C; a_wd = 32'hDEAD_BEEF;
    step(); step(); #2;
    check("aux_inv_err", aux_err, 1);
    check("aux_inv_rdata", aux_rdata, 0);
    a_req = 0; step();
    a_req = 1; a_we = 0; a_addr = 32'h8000;
    step(); step(); #2;
    check("aux_oob_err", aux_err, 1);
    a_req = 0;
    c_req = 1; c_we = 1; c_addr = 32'h7F0C; c_wd = $urandom();
    step(); #2;
    check("cpu_inv_hit", cpu_hit, 0);
    check("cpu_inv_rd", cpu_rd, 0);
    check("cpu_inv_we", t0_we | t1_we, 0);
    quiet();

    // Abandon during WAIT, then reset while an ACK is showing
    a_req = 1; a_we = 1; a_addr = 32'h7F08; a_wd = $urandom();
    c_req = 1; c_we = 0; c_addr = 32'h7F00;
    step(); step();
    a_req = 0;
    step(); #2;
    check("drop_no_we", t0_we | t1_we, 0);
    c_req = 0; step();
    a_req = 1; a_we = 1; a_addr = 32'h7F18; a_wd = $urandom();
    step();
    rst_i = 1;
    step(); #2;
    check("rst_during_ack", aux_ack, 1);
    step(); #2;
    check("rst_no_we", t0_we | t1_we, 0);
    rst_i = 0; a_req = 0;
    step(); #2;
    check("post_rst_ack", aux_ack, 0);
    check("post_rst_hwint", hwint, 0);

    // Interrupt mirroring
    i0 = 1; step();
    i1 = 1; step(); #2;
    check("hwint_t0", hwint, 6'b000001);
    step(); #2;
    check("hwint_both", hwint, 6'b000011);
    i0 = 0; i1 = 0;

    // Randomized traffic
    busy = 1'b0;
    drop_next = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 64 == 0) busy = 1'($urandom_range(0, 1));
      c_req  = busy ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
      c_we   = 1'($urandom_range(0, 1));
      c_addr = rand_addr();
      c_wd   = $urandom();
      if (drop_next) a_req = 0;
      drop_next = in_ack;
      if (a_req && blocked > 0 && $urandom_range(0, 15) == 0) begin
        a_req = 0;
      end else if (!a_req && $urandom_range(0, 2) == 0) begin
        a_req = 1; a_we = 1'($urandom_range(0, 1)); a_addr = rand_addr(); a_wd = $urandom();
      end
      if ($urandom_range(0, 7) == 0) i0 = ~i0;
      if ($urandom_range(0, 7) == 0) i1 = ~i1;
      step();
    end

    quiet();
    repeat (4) step();
    #2;
    check("drain_writes", wr_q.size(), 0);
    check("drain_acks", aux_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
